// File: rtl/leds_racer_pkg.sv
// Shared definitions for the racer LED path: WS2812 timing at 50 MHz,
// the GRB colour type, the frame driver state encoding and width helpers.
package leds_racer_pkg;

    localparam int WS_NUM_LEDS  = 110;
    localparam int WS_T0H_CLK   = 20;
    localparam int WS_T1H_CLK   = 40;
    localparam int WS_TBIT_CLK  = 63;
    localparam int WS_LATCH_CLK = 15000;

    typedef logic [23:0] grb_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        LATCH
    } drv_state_t;

    // Pixel index width; a single-LED strip still needs a one-bit address.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width covering the larger of two cycle bounds.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ws2812_frame_driver_if.sv
// Renderer <-> frame driver connection: start pulse, pixel fetch and strip outputs.
// The renderer side is the master, the frame driver is the slave.
interface ws2812_frame_driver_if
    import leds_racer_pkg::*;
#(
    parameter int NUM_LEDS = WS_NUM_LEDS
);
    localparam int AW = addr_width(NUM_LEDS);

    logic          update_frame;
    logic          pixel_req;
    logic [AW-1:0] pixel_addr;
    grb_t          pixel_data;
    logic          leds_line;
    logic          busy;
    logic          frame_done;

    modport master (
        output update_frame,
        output pixel_data,
        input  pixel_req,
        input  pixel_addr,
        input  leds_line,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  update_frame,
        input  pixel_data,
        output pixel_req,
        output pixel_addr,
        output leds_line,
        output busy,
        output frame_done
    );

endinterface

// File: rtl/ws2812_bit_encoder.sv
// Produces the WS2812 high/low waveform of one bit period at a time.
// The line level is registered from the upcoming count value, so the line
// follows the encoder's own count with no extra cycle of lag.
module ws2812_bit_encoder #(
    parameter int T0H_CLK  = 20,
    parameter int T1H_CLK  = 40,
    parameter int TBIT_CLK = 63,
    parameter int CW       = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_bit,
    output logic o_line,
    output logic o_bit_done
);

    logic [CW-1:0] r_clk_cnt;
    logic          r_active;
    logic          r_line;
    logic [CW-1:0] w_high_len;
    logic [CW-1:0] w_cnt_inc;
    logic          w_last;

    assign w_high_len = i_bit ? CW'(T1H_CLK) : CW'(T0H_CLK);
    assign w_cnt_inc  = r_clk_cnt + CW'(1);
    assign w_last     = r_active && (r_clk_cnt == CW'(TBIT_CLK - 1));

    // Bit period counter and registered line level; a start restarts the period even on the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt <= '0;
            r_active  <= 1'b0;
            r_line    <= 1'b0;
        end else if (i_start) begin
            r_clk_cnt <= '0;
            r_active  <= 1'b1;
            r_line    <= (w_high_len != '0);
        end else if (w_last) begin
            r_clk_cnt <= '0;
            r_active  <= 1'b0;
            r_line    <= 1'b0;
        end else if (r_active) begin
            r_clk_cnt <= w_cnt_inc;
            r_line    <= (w_cnt_inc < w_high_len);
        end
    end

    assign o_line     = r_line;
    assign o_bit_done = w_last;

endmodule

// File: rtl/ws2812_frame_driver.sv
// Walks the strip one pixel at a time: fetch colour, load it, shift its 24 bits
// out MSB first through the bit encoder, then hold the line low for the latch gap.
module ws2812_frame_driver
    import leds_racer_pkg::*;
#(
    parameter int NUM_LEDS  = WS_NUM_LEDS,
    parameter int T0H_CLK   = WS_T0H_CLK,
    parameter int T1H_CLK   = WS_T1H_CLK,
    parameter int TBIT_CLK  = WS_TBIT_CLK,
    parameter int LATCH_CLK = WS_LATCH_CLK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ws2812_frame_driver_if.slave  bus
);

    localparam int AW = addr_width(NUM_LEDS);
    localparam int CW = cnt_width(TBIT_CLK, LATCH_CLK);

    if (T0H_CLK >= T1H_CLK || T1H_CLK >= TBIT_CLK || NUM_LEDS < 1) begin : g_bad_params
        $error("ws2812_frame_driver: need T0H_CLK < T1H_CLK < TBIT_CLK and NUM_LEDS >= 1");
    end

    drv_state_t    r_state;
    drv_state_t    w_state_next;
    logic [AW-1:0] r_idx;
    grb_t          r_shreg;
    logic [4:0]    r_bit_cnt;
    logic [CW-1:0] r_latch_cnt;
    logic          r_busy;
    logic          r_frame_done;

    logic          w_accept;
    logic          w_enc_start;
    logic          w_enc_bit;
    logic          w_enc_line;
    logic          w_bit_done;
    logic          w_last_bit;
    logic          w_last_led;
    logic          w_latch_end;

    // A start is only taken in IDLE and never in the cycle that reports the previous frame done.
    assign w_accept    = (r_state == IDLE) && bus.update_frame && !r_frame_done;
    assign w_last_bit  = (r_bit_cnt == 5'd23);
    assign w_last_led  = (r_idx == AW'(NUM_LEDS - 1));
    assign w_latch_end = (r_latch_cnt == CW'(LATCH_CLK - 1));

    ws2812_bit_encoder #(
        .T0H_CLK  (T0H_CLK),
        .T1H_CLK  (T1H_CLK),
        .TBIT_CLK (TBIT_CLK),
        .CW       (CW)
    ) u_bit_encoder (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_enc_start),
        .i_bit      (w_enc_bit),
        .o_line     (w_enc_line),
        .o_bit_done (w_bit_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus encoder control; a new bit starts from fresh pixel data in LOAD or from the next shreg bit in SEND.
    always_comb begin
        w_state_next = r_state;
        w_enc_start  = 1'b0;
        w_enc_bit    = r_shreg[23];
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_state_next = LOAD;
            end
            LOAD: begin
                w_state_next = SEND;
                w_enc_start  = 1'b1;
                w_enc_bit    = bus.pixel_data[23];
            end
            SEND: begin
                if (w_bit_done) begin
                    if (w_last_bit) begin
                        w_state_next = w_last_led ? LATCH : FETCH;
                    end else begin
                        w_enc_start = 1'b1;
                        w_enc_bit   = r_shreg[22];
                    end
                end
            end
            LATCH: begin
                if (w_latch_end) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pixel index, shift register, bit and latch counters, busy and the frame-done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_latch_cnt  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    r_shreg   <= bus.pixel_data;
                    r_bit_cnt <= '0;
                end
                SEND: begin
                    if (w_bit_done) begin
                        r_shreg   <= r_shreg << 1;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (w_last_bit) begin
                            r_latch_cnt <= '0;
                            if (!w_last_led) begin
                                r_idx <= r_idx + AW'(1);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (w_latch_end) begin
                        r_latch_cnt  <= '0;
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_latch_cnt <= r_latch_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pixel_req  = (r_state == FETCH);
    assign bus.pixel_addr = r_idx;
    assign bus.leds_line  = w_enc_line;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench for ws2812_frame_driver with a 3-LED strip and short timing.
module tb_ws2812_frame_driver;
    import leds_racer_pkg::*;

    localparam int NumLeds = 3;
    localparam int T0h     = 2;
    localparam int T1h     = 4;
    localparam int TBit    = 6;
    localparam int TLatch  = 10;
    localparam int FrameWindow = 470;

    logic clk = 1'b0;
    logic rst_n;

    ws2812_frame_driver_if #(.NUM_LEDS(NumLeds)) bus ();

    ws2812_frame_driver #(
        .NUM_LEDS  (NumLeds),
        .T0H_CLK   (T0h),
        .T1H_CLK   (T1h),
        .TBIT_CLK  (TBit),
        .LATCH_CLK (TLatch)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   assertCount = 0;
    int   failCount   = 0;
    int   holdCnt     = 0;
    grb_t colours [NumLeds];
    logic expLine [$];
    logic obsLine [$];
    logic obsBusy [$];
    logic obsReq  [$];
    int   reqAddrs [$];

    // Compare one observed value with its hand-derived expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive update_frame for one clock, then sample just after the edge and act as the renderer's pixel memory.
    task automatic applyStimulus(input logic upd);
        bus.update_frame = upd;
        @(posedge clk);
        #1;
        if (bus.pixel_req) begin
            bus.pixel_data = (int'(bus.pixel_addr) < NumLeds) ? colours[bus.pixel_addr] : 24'h5A5A5A;
            holdCnt = 1;
        end else if (holdCnt == 1) begin
            holdCnt = 0;
        end else begin
            bus.pixel_data = 24'h5A5A5A;
        end
    endtask

    // Length of the run of equal line levels starting at a sample index.
    function automatic int runLen(input int start, input logic val);
        int n = 0;
        for (int i = start; i < obsLine.size(); i++) begin
            if (obsLine[i] !== val) break;
            n++;
        end
        return n;
    endfunction

    initial begin
        int   idleNoise;
        int   frameDoneAt;
        int   frameDoneSeen;
        int   firstHigh;
        int   lastHigh;
        int   mism;
        int   quietReq;
        int   quietDone;
        int   addrSeen [3];

        colours[0] = 24'h800001;
        colours[1] = 24'h0F00F0;
        colours[2] = 24'hC33C81;

        // Reference waveform: two idle cycles per LED, then 24 bits MSB first, then the latch gap.
        for (int led = 0; led < NumLeds; led++) begin
            expLine.push_back(1'b0);
            expLine.push_back(1'b0);
            for (int b = 23; b >= 0; b--) begin
                int th;
                th = colours[led][b] ? T1h : T0h;
                for (int c = 0; c < TBit; c++) expLine.push_back(c < th);
            end
        end
        for (int c = 0; c < TLatch; c++) expLine.push_back(1'b0);
        while (expLine.size() < FrameWindow) expLine.push_back(1'b0);

        // Reset values.
        rst_n = 1'b0;
        bus.update_frame = 1'b0;
        bus.pixel_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetLine",  bus.leds_line,  0);
        checkOutput("resetBusy",  bus.busy,       0);
        checkOutput("resetDone",  bus.frame_done, 0);
        checkOutput("resetReq",   bus.pixel_req,  0);
        checkOutput("resetAddr",  bus.pixel_addr, 0);

        @(negedge clk) rst_n = 1'b1;
        idleNoise = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0);
            if (bus.leds_line || bus.busy || bus.pixel_req || bus.frame_done) idleNoise++;
        end
        checkOutput("idleQuiet", idleNoise, 0);

        // Full frame, with extra starts while busy (k=100) and in the frame_done cycle (k=448).
        frameDoneAt = -1;
        frameDoneSeen = 0;
        for (int k = 0; k < FrameWindow; k++) begin
            applyStimulus((k == 0 || k == 101 || k == 449) ? 1'b1 : 1'b0);
            obsLine.push_back(bus.leds_line);
            obsBusy.push_back(bus.busy);
            obsReq.push_back(bus.pixel_req);
            if (bus.pixel_req) reqAddrs.push_back(int'(bus.pixel_addr));
            if (bus.frame_done) begin
                frameDoneSeen++;
                frameDoneAt = k;
            end
        end

        firstHigh = -1;
        lastHigh = -1;
        for (int k = 0; k < FrameWindow; k++) begin
            if (obsLine[k] === 1'b1 && firstHigh < 0) firstHigh = k;
            if (obsLine[k] === 1'b1 && k < 448) lastHigh = k;
        end
        mism = 0;
        for (int k = 0; k < FrameWindow; k++) begin
            if (obsLine[k] !== expLine[k]) mism++;
        end

        checkOutput("reqLatency",   obsReq[0],  1);
        checkOutput("busyAtStart",  obsBusy[0], 1);
        checkOutput("firstHighK",   firstHigh,  2);
        checkOutput("bit0High",     runLen(2, 1'b1),   4);
        checkOutput("bit0Low",      runLen(6, 1'b0),   2);
        checkOutput("bit1High",     runLen(8, 1'b1),   2);
        checkOutput("bit1Low",      runLen(10, 1'b0),  4);
        checkOutput("bit22High",    runLen(134, 1'b1), 2);
        checkOutput("bit23High",    runLen(140, 1'b1), 4);
        checkOutput("interLedLow",  runLen(144, 1'b0), (TBit - T1h) + 2);
        checkOutput("waveMismatch", mism, 0);

        for (int i = 0; i < 3; i++) addrSeen[i] = (i < reqAddrs.size()) ? reqAddrs[i] : -1;
        checkOutput("reqCount", reqAddrs.size(), 3);
        checkOutput("reqAddr0", addrSeen[0], 0);
        checkOutput("reqAddr1", addrSeen[1], 1);
        checkOutput("reqAddr2", addrSeen[2], 2);

        checkOutput("frameDoneAt",   frameDoneAt, 448);
        checkOutput("frameDoneOnce", frameDoneSeen, 1);
        checkOutput("latchGap",      frameDoneAt - (lastHigh + 1), (TBit - T1h) + TLatch);
        checkOutput("busyLatchEnd",  obsBusy[447], 1);
        checkOutput("busyAtDone",    obsBusy[448], 0);
        checkOutput("busyAfter",     obsBusy[FrameWindow-1], 0);

        // New frame, then reset in the middle of a high phase of LED 1 (bit 4 high spans k=172..175).
        applyStimulus(1'b1);
        for (int k = 1; k <= 173; k++) applyStimulus(1'b0);
        checkOutput("preResetLine", bus.leds_line,  1);
        checkOutput("preResetAddr", bus.pixel_addr, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midResetLine", bus.leds_line,  0);
        checkOutput("midResetBusy", bus.busy,       0);
        checkOutput("midResetAddr", bus.pixel_addr, 0);
        checkOutput("midResetDone", bus.frame_done, 0);

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        quietReq = 0;
        quietDone = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0);
            if (bus.pixel_req) quietReq++;
            if (bus.frame_done) quietDone++;
        end
        checkOutput("postResetNoReq",  quietReq,  0);
        checkOutput("postResetNoDone", quietDone, 0);

        applyStimulus(1'b1);
        checkOutput("restartReq",  bus.pixel_req,  1);
        checkOutput("restartAddr", bus.pixel_addr, 0);
        applyStimulus(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
